d_debounce_sync: RTL
====================

// Module: d_debounce_sync
// PURPOSE
//   Conditions an asynchronous, bouncy level input before it drives the d input of the dflip storage stage.
//   - Synchronises d_raw into the clk domain.
//   - Debounces it by requiring DEBOUNCE_CYCLES consecutive equal samples.
//   - Presents a clean level plus single-cycle rise/fall pulses to the downstream dflip and its consumers.
// PARAMETERS
//   SYNC_STAGES      2   flops in synchroniser chain; legal >= 2
//   DEBOUNCE_CYCLES  4   consecutive synced samples needed to accept a change; legal >= 2
//   CNT_W            3   counter width; must hold DEBOUNCE_CYCLES-1 ($clog2(DEBOUNCE_CYCLES) minimum)
// PORTS
//   clk         input   1  rising-edge clock, single domain
//   reset       input   1  synchronous, active-high reset
//   d_raw       input   1  asynchronous raw level (switch/pin)
//   d_clean     output  1  debounced level; drives dflip.d
//   d_clean_bar output  1  ~d_clean, combinational
//   rise_pulse  output  1  1 cycle high when d_clean goes 0->1
//   fall_pulse  output  1  1 cycle high when d_clean goes 1->0
//   busy        output  1  high while a candidate change is being qualified
// BEHAVIOUR
//   Reset (sampled at posedge clk while reset=1):
//   - sync chain = 0; state = ST_LOW; cnt = 0.
//   - d_clean = 0, rise_pulse = 0, fall_pulse = 0, busy = 0.
//   - Reset has priority over all other activity and aborts any qualification in progress.
//   Synchroniser: sync[0] <= d_raw, sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1].
//   FSM, 4 states, evaluated every posedge:
//   - ST_LOW:   s=1 -> ST_WAIT_H, cnt <= 1; else stay.
//   - ST_WAIT_H:
//       s=0 -> ST_LOW, cnt <= 0 (bounce rejected; no pulse).
//       s=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HIGH, d_clean <= 1, rise_pulse <= 1, cnt <= 0.
//       else cnt <= cnt+1.
//   - ST_HIGH:  s=0 -> ST_WAIT_L, cnt <= 1; else stay.
//   - ST_WAIT_L: mirror of ST_WAIT_H (s=1 aborts to ST_HIGH; on completion d_clean <= 0, fall_pulse <= 1).
//   Outputs:
//   - busy = registered (state==ST_WAIT_H || state==ST_WAIT_L).
//   - rise_pulse/fall_pulse deassert the cycle after they assert; never both high.
//   Latency: d_raw stable from posedge E0 onward -> d_clean changes at posedge E(SYNC_STAGES+DEBOUNCE_CYCLES-1).
//   Default parameters give 6th edge (E5).
//   Bounce: any opposite sample inside a wait window restarts qualification from zero; there is no partial credit.
//   Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 and is cleared on every state exit.
//   Reset mid-wait: qualification is discarded.
//   - If d_raw is still high after release, the full latency from release applies.
//   - Pulses are never generated by reset itself.
//   Pulses vs. level: a pulse is high in the same cycle d_clean first shows the new level.
// STRUCTURE
//   d_debounce_pkg.vh: state localparams ST_LOW=2'd0, ST_WAIT_H=2'd1, ST_HIGH=2'd2, ST_WAIT_L=2'd3.
//   Sub-module sync_chain #(STAGES): parameterised flop chain (clk, reset, in, out), sync reset to 0.
//   Top: one sync_chain instance + FSM/counter always block + output regs.
// TESTING
//   1 Reset held 3 cycles with d_raw=1 -> d_clean=0, pulses=0, busy=0 throughout reset.
//   2 Clean step: d_raw 0->1 before E0, held -> d_clean=1 and rise_pulse=1 at E5 only; rise_pulse=0 at E6.
//   3 Bounce: d_raw=1 for 2 cycles, 0 for 1, then 1 held -> no rise during glitch; d_clean rises 6 edges after final 0->1.
//   4 Glitch rejection: single-cycle d_raw pulses every 3 cycles for 30 cycles -> d_clean stays 0, no pulses, busy toggles.
//   5 Fall: from d_clean=1, d_raw->0 held -> d_clean=0 and fall_pulse=1 at E5; d_clean_bar=1 same cycle.
//   6 Reset mid-wait: assert reset during ST_WAIT_H (cnt=2), release with d_raw=1 -> busy=0 in reset; d_clean rises 6 edges after release.

Source files
------------

// File: rtl/d_debounce_pkg.sv
// Shared constants for the d_debounce_sync block: FSM state encodings and helpers.
package d_debounce_pkg;

  localparam logic [1:0] ST_LOW    = 2'd0;
  localparam logic [1:0] ST_WAIT_H = 2'd1;
  localparam logic [1:0] ST_HIGH   = 2'd2;
  localparam logic [1:0] ST_WAIT_L = 2'd3;

  // Both wait states have bit 0 set; busy is simply "in a qualification window".
  function automatic logic is_wait(input logic [1:0] st);
    return (st == ST_WAIT_H) || (st == ST_WAIT_L);
  endfunction

endpackage

// File: rtl/d_debounce_sync_chain.sv
// Parameterised flop chain used as a metastability synchroniser, cleared by synchronous reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) chain_q <= '0;
    else       chain_q <= {chain_q[STAGES-2:0], in_i};
  end

  assign out_o = chain_q[STAGES-1];

endmodule

// File: rtl/d_debounce_sync.sv
// Synchronises and debounces a raw level input, producing a clean level plus rise/fall pulses.
module d_debounce_sync
  import d_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic d_clean,
  output logic d_clean_bar,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .in_i  (d_raw),
    .out_o (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: if (s) begin
        state_d = ST_WAIT_H;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT_H: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
          clean_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: if (!s) begin
        state_d = ST_WAIT_L;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT_L: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
          clean_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= is_wait(state_d);
    end
  end

  assign d_clean     = clean_q;
  assign d_clean_bar = ~clean_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign busy        = busy_q;

endmodule
